bp_pktfifo_arbiter: RTL and testbench
=====================================

// Module: bp_pktfifo_arbiter
// PURPOSE
//  Shares the single device-to-host USB byte stream between N_SRC correlator packet FIFOs.
//  Grants one source at a time, round-robin, and drains exactly one whole packet per grant.
//  Sits between the per-pair pktfifo outputs (show-ahead: data valid while not empty) and the
//  i_devToHost_* valid/ready input of the USB serial device.
// PARAMETERS
//  N_SRC    2  number of packet sources, 1..16
//  PKT_LEN  8  payload bytes per packet, 1..255
// PORTS
//  i_clk      in   1         sole clock, rising edge
//  i_rst_n    in   1         asynchronous active-low reset
//  i_pktRdy   in   N_SRC     [s]=1: FIFO s holds >=1 complete packet
//  i_data     in   N_SRC*8   head byte of FIFO s at [s*8+:8]
//  o_pop      out  N_SRC     one-hot pop strobe to granted FIFO
//  i_flush    in   N_SRC     [s]=1: FIFO s is being flushed this cycle
//  o_data     out  8         byte to USB serial
//  o_valid    out  1         o_data valid
//  i_ready    in   1         USB serial accepts byte
//  o_grant    out  N_SRC     one-hot current owner, 0 when idle
//  o_busy     out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset: o_valid=0, o_pop=0, o_grant=0, o_busy=0, state=IDLE, byteCnt=0, lastGrant=N_SRC-1
//   (first grant goes to source 0). Reset asserted mid-packet abandons it immediately.
//  States: IDLE -> (HDR) -> SEND -> IDLE.
//  IDLE: if |i_pktRdy, pick the first ready s scanning lastGrant+1, lastGrant+2, ... (mod N_SRC).
//   Register grant and lastGrant=s. Next state is HDR if the header feature is on, else SEND.
//   Grant-to-first-valid latency is 1 cycle. No i_pktRdy: remain IDLE, o_valid=0.
//  HDR: o_valid=1, o_data=HDR byte. On i_ready go to SEND. o_pop stays 0.
//  SEND: o_valid=1, o_data=i_data[grant*8+:8] (combinational mux).
//   o_pop[grant] = o_valid & i_ready (same cycle as acceptance).
//   byteCnt increments per accepted byte.
//   When the byte with byteCnt==PKT_LEN-1 is accepted: byteCnt=0, state=IDLE.
//  At least one IDLE cycle between packets. Back-to-back from one source is allowed only if
//   no other source is ready.
//  Handshake: while o_valid=1 and i_ready=0, o_data and o_grant are held stable.
//   Sole exception is flush.
//  Flush, granted source (i_flush[grant]=1 in HDR/SEND): no pop that cycle.
//   Next cycle: state=IDLE, o_valid=0, byteCnt=0. The packet is truncated; host reframes.
//   lastGrant keeps the flushed index.
//  Flush, non-granted source: ignored by the arbiter.
//  Flush coincident with the final-byte acceptance: flush wins, so no pop occurs.
//  i_pktRdy of the granted source is not sampled after grant.
//   The FIFO guarantees PKT_LEN bytes are present.
//  byteCnt width: $clog2(PKT_LEN+1). lastGrant width: $clog2(N_SRC), minimum 1.
// CONFIGURATION
//  BP_PKTARB_HEADER_EN defined:
//   each packet is preceded by one byte {4'hA, src[3:0]}, so a packet is PKT_LEN+1 bytes.
//   The HDR state exists and the flush rule applies in HDR.
//  BP_PKTARB_HEADER_EN undefined:
//   no HDR state, raw PKT_LEN-byte packets, IDLE goes directly to SEND.
// STRUCTURE
//  Package bp_pkg:
//   - state typedef enum {IDLE, HDR, SEND}
//   - HDR_MAGIC = 4'hA
//   - function for the header byte
//  Sub-module bp_rr_pick:
//   - pure combinational round-robin selector
//   - inputs: req[N_SRC], last[idx]
//   - outputs: one-hot gnt, binary idx, any
//  The FSM, byteCnt, output mux and pop logic live in this module.
// TESTING
//  T1 reset: assert i_rst_n=0 mid-SEND, asynchronously
//   -> o_valid, o_pop, o_grant go to 0 without waiting for a clock edge.
//   First later grant is to src0.
//  T2 single source, N_SRC=2, PKT_LEN=8, i_ready=1, src1 ready
//   -> grant=2'b10 one cycle later; 8 consecutive pops; o_busy falls after byte 8.
//  T3 fairness, both sources ready continuously
//   -> packet order 0,1,0,1; each exactly PKT_LEN bytes (+1 with HDR_EN, hdr 8'hA0 / 8'hA1).
//  T4 backpressure: i_ready random 30% duty
//   -> o_data stable while stalled, no pop without i_ready; byte order equals FIFO order.
//  T5 flush of src0 at byteCnt=3 -> no pop that cycle; o_valid=0 next cycle;
//   a pending src1 is granted next. A flush on non-granted src1 does not disturb src0.
//  T6 flush coincident with final byte accept -> o_pop=0, state=IDLE.
//   Scoreboard records a truncated packet.

Source files
------------

// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the packet-FIFO arbiter.
//   state_t   : arbiter FSM states (HDR only reachable with BP_PKTARB_HEADER_EN)
//   HDR_MAGIC : upper nibble of the optional per-packet header byte
//   hdr_byte  : builds the header byte {HDR_MAGIC, src[3:0]}
// ----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    function automatic logic [7:0] hdr_byte(input logic [3:0] src);
        return {HDR_MAGIC, src};
    endfunction

endpackage

// File: rtl/bp_rr_pick.sv
// ----------------------------------------------------------------------------
// bp_rr_pick
// Purely combinational round-robin selector. Scans requests starting at the
// index after last_i, wrapping modulo N_SRC, and reports the first hit.
// Ports:
//   req_i  [N_SRC] : request vector
//   last_i [IW]    : index granted most recently
//   gnt_o  [N_SRC] : one-hot pick (all zero when nothing requested)
//   idx_o  [IW]    : binary index of the pick
//   any_o          : at least one request present
// ----------------------------------------------------------------------------
module bp_rr_pick #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned IW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic found;

    // The circular scan is split into two linear passes (indices above last,
    // then indices up to and including last) so every bit select stays a
    // loop constant.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!found && req_i[i] && (i > 32'(last_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!found && req_i[i] && (i <= 32'(last_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/bp_pktfifo_arbiter.sv
// ----------------------------------------------------------------------------
// bp_pktfifo_arbiter
// Shares the device-to-host USB byte stream between N_SRC show-ahead packet
// FIFOs. One source is granted at a time, round-robin, and exactly one whole
// packet is drained per grant; at least one IDLE cycle separates packets.
//
// Optional feature (macro BP_PKTARB_HEADER_EN): each packet is preceded by a
// header byte {4'hA, src[3:0]}, sent from the HDR state.
//
// Parameters: N_SRC (1..16) sources, PKT_LEN (1..255) payload bytes/packet.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_pktRdy[s]    : FIFO s holds at least one complete packet
//   i_data         : head byte of FIFO s at [s*8+:8]
//   i_flush[s]     : FIFO s is being flushed this cycle
//   o_pop          : one-hot pop strobe, same cycle as byte acceptance
//   o_data/o_valid : byte stream to USB serial, i_ready accepts it
//   o_grant        : one-hot current owner, zero while idle
//   o_busy         : FSM not in IDLE
// ----------------------------------------------------------------------------
module bp_pktfifo_arbiter
    import bp_pkg::*;
#(
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned PKT_LEN = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_SRC-1:0]   i_pktRdy,
    input  logic [N_SRC*8-1:0] i_data,
    output logic [N_SRC-1:0]   o_pop,
    input  logic [N_SRC-1:0]   i_flush,
    output logic [7:0]         o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [N_SRC-1:0]   o_grant,
    output logic               o_busy
);

    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CW = $clog2(PKT_LEN + 1);

    localparam logic [CW-1:0] LAST_BYTE = CW'(PKT_LEN - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_SRC - 1);

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [IW-1:0]      gidx_q,  gidx_d;
    logic [IW-1:0]      last_q,  last_d;
    logic [CW-1:0]      cnt_q,   cnt_d;

    logic [N_SRC-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [7:0]         head_byte;
    logic               flush_g;

    bp_rr_pick #(
        .N_SRC (N_SRC),
        .IW    (IW)
    ) u_pick (
        .req_i  (i_pktRdy),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Head byte of the granted FIFO.
    always_comb begin
        head_byte = '0;
        for (int unsigned s = 0; s < N_SRC; s++) begin
            if (gidx_q == IW'(s)) begin
                head_byte = i_data[s*8 +: 8];
            end
        end
    end

    // Flushes of non-granted sources are deliberately ignored.
    assign flush_g = |(i_flush & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        o_valid = 1'b0;
        o_data  = '0;
        o_pop   = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
`ifdef BP_PKTARB_HEADER_EN
                    state_d = HDR;
`else
                    state_d = SEND;
`endif
                end
            end

`ifdef BP_PKTARB_HEADER_EN
            HDR: begin
                o_valid = 1'b1;
                o_data  = hdr_byte(4'(gidx_q));
                if (flush_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (i_ready) begin
                    state_d = SEND;
                end
            end
`endif

            SEND: begin
                o_valid = 1'b1;
                o_data  = head_byte;
                // A flush wins over acceptance, including on the final byte:
                // no pop, packet truncated, lastGrant keeps this source.
                if (flush_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (i_ready) begin
                    o_pop = grant_q;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_bp_pktfifo_arbiter.sv
module tb_bp_pktfifo_arbiter;

    localparam int N       = 2;
    localparam int PKT_LEN = 8;
`ifdef BP_PKTARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FRAME = PKT_LEN + HDR;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   i_pktRdy;
    logic [N*8-1:0] i_data;
    logic [N-1:0]   o_pop;
    logic [N-1:0]   i_flush;
    logic [7:0]     o_data;
    logic           o_valid;
    logic           i_ready;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    always #5 clk = ~clk;

    bp_pktfifo_arbiter #(
        .N_SRC   (N),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_pktRdy (i_pktRdy),
        .i_data   (i_data),
        .o_pop    (o_pop),
        .i_flush  (i_flush),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    int checks = 0;
    int errors = 0;

    // Environment / reference model: FIFO contents plus a transaction view of
    // the arbiter (owner index or -1, position inside the framed packet).
    logic [7:0] fifo [N][$];
    int owner  = -1;
    int pos    = 0;
    int last_g = N - 1;

    logic         cur_rdy;
    logic [N-1:0] cur_fl;
    logic [N-1:0] cur_pr;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data  = 8'h00;

    // DUT-observed packet log
    logic [N-1:0] prev_grant = '0;
    int           cur_len    = 0;
    int           dut_pops   = 0;
    int           dut_grant_log[$];
    int           dut_len_log[$];

    typedef struct {
        logic         rdy;
        logic [N-1:0] fl;
        logic         valid;
        logic [N-1:0] grant;
        logic [N-1:0] pop;
        logic         busy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int s);
        for (int b = 0; b < PKT_LEN; b++) fifo[s].push_back(8'($urandom));
    endtask

    function automatic logic any_ready();
        logic r = 1'b0;
        for (int s = 0; s < N; s++) if (fifo[s].size() >= PKT_LEN) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        owner  = -1;
        pos    = 0;
        last_g = N - 1;
        for (int s = 0; s < N; s++) fifo[s].delete();
        prev_stall = 1'b0;
        prev_grant = '0;
        cur_len    = 0;
    endtask

    // Drive inputs from the environment state, then compare DUT outputs.
    task automatic drive_and_check(input logic rdy, input logic [N-1:0] fl);
        logic         ev;
        logic [N-1:0] eg;
        logic [N-1:0] ep;
        logic [7:0]   ed;
        cur_rdy = rdy;
        cur_fl  = fl;
        for (int s = 0; s < N; s++) begin
            cur_pr[s]        = (fifo[s].size() >= PKT_LEN);
            i_data[s*8 +: 8] = (fifo[s].size() > 0) ? fifo[s][0] : 8'h00;
        end
        i_pktRdy = cur_pr;
        i_ready  = rdy;
        i_flush  = fl;
        #1;
        ev = (owner >= 0);
        eg = '0;
        ep = '0;
        if (ev) begin
            eg[owner] = 1'b1;
            if (rdy && !fl[owner] && pos >= HDR) ep = eg;
        end
        chk("valid", 32'(o_valid), 32'(ev));
        chk("busy",  32'(o_busy),  32'(ev));
        chk("grant", 32'(o_grant), 32'(eg));
        chk("pop",   32'(o_pop),   32'(ep));
        if (ev) begin
            ed = (pos < HDR) ? {4'hA, 4'(owner)} : fifo[owner][0];
            chk("data", 32'(o_data), 32'(ed));
        end
        if (prev_stall) chk("hold_data", 32'(o_data), 32'(prev_data));
        prev_stall = ev && !rdy && !fl[owner];
        prev_data  = o_data;
        if (o_pop != '0) dut_pops++;
        if (prev_grant == '0 && o_grant != '0) dut_grant_log.push_back(int'(o_grant));
        if (prev_grant != '0 && o_grant == '0) begin
            dut_len_log.push_back(cur_len);
            cur_len = 0;
        end
        if (o_valid && rdy && ((fl & o_grant) == '0)) cur_len++;
        prev_grant = o_grant;
    endtask

    task automatic model_edge();
        logic [7:0] dummy;
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_g + k) % N;
                if (owner < 0 && cur_pr[c]) owner = c;
            end
            if (owner >= 0) begin
                last_g = owner;
                pos    = 0;
            end
        end else if (cur_fl[owner]) begin
            owner = -1;
            pos   = 0;
        end else if (cur_rdy) begin
            if (pos >= HDR) dummy = fifo[owner].pop_front();
            pos++;
            if (pos == FRAME) begin
                owner = -1;
                pos   = 0;
            end
        end
        for (int s = 0; s < N; s++) if (cur_fl[s]) fifo[s].delete();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step(input logic rdy, input logic [N-1:0] fl);
        drive_and_check(rdy, fl);
        finish_cycle();
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (owner >= 0 || any_ready()); i++) step(1'b1, '0);
        step(1'b1, '0);
        chk("drain_idle", 32'(o_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int exp_order[4];
        int guard;
        rst_n    = 1'b0;
        i_pktRdy = '0;
        i_data   = '0;
        i_flush  = '0;
        i_ready  = 1'b0;
        cur_pr   = '0;
        cur_fl   = '0;
        cur_rdy  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_pop",   32'(o_pop),   32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        rst_n = 1'b1;

        // T1: asynchronous reset mid-packet
        push_pkt(0);
        repeat (4) step(1'b1, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid", 32'(o_valid), 32'd0);
        chk("t1_async_pop",   32'(o_pop),   32'd0);
        chk("t1_async_grant", 32'(o_grant), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(0);
        push_pkt(1);
        step(1'b1, '0);
        chk("t1_first_grant", 32'(o_grant), 32'd1);
        drain(100);

        // T2: single source (src1), table-driven
        begin
            vec_t v;
            v.rdy = 1'b1; v.fl = '0; v.valid = 1'b0; v.grant = '0; v.pop = '0; v.busy = 1'b0;
            tbl.push_back(v);
            for (int k = 1; k <= FRAME; k++) begin
                v.valid = 1'b1;
                v.grant = 2'b10;
                v.pop   = (k - 1 >= HDR) ? 2'b10 : 2'b00;
                v.busy  = 1'b1;
                tbl.push_back(v);
            end
            v.valid = 1'b0; v.grant = '0; v.pop = '0; v.busy = 1'b0;
            tbl.push_back(v);
        end
        push_pkt(1);
        base = dut_pops;
        for (int i = 0; i < tbl.size(); i++) begin
            drive_and_check(tbl[i].rdy, tbl[i].fl);
            chk("t2_valid", 32'(o_valid), 32'(tbl[i].valid));
            chk("t2_grant", 32'(o_grant), 32'(tbl[i].grant));
            chk("t2_pop",   32'(o_pop),   32'(tbl[i].pop));
            chk("t2_busy",  32'(o_busy),  32'(tbl[i].busy));
            finish_cycle();
        end
        chk("t2_pop_count", 32'(dut_pops - base), 32'(PKT_LEN));

        // T3: fairness with both sources continuously ready
        dut_grant_log.delete();
        dut_len_log.delete();
        push_pkt(0); push_pkt(0);
        push_pkt(1); push_pkt(1);
        drain(200);
        exp_order = '{1, 2, 1, 2};
        chk("t3_npkts", 32'(dut_grant_log.size()), 32'd4);
        for (int i = 0; i < dut_grant_log.size() && i < 4; i++)
            chk("t3_order", 32'(dut_grant_log[i]), 32'(exp_order[i]));
        for (int i = 0; i < dut_len_log.size(); i++)
            chk("t3_len", 32'(dut_len_log[i]), 32'(FRAME));

        // T4: random traffic with ~30% ready duty
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 9) < 2) begin
                int s;
                s = int'($urandom_range(0, N - 1));
                if (fifo[s].size() < 3 * PKT_LEN) push_pkt(s);
            end
            step($urandom_range(0, 9) < 3, '0);
        end
        drain(400);

        // T5: flush granted src0 at byteCnt=3; non-granted flush ignored
        do_reset();
        push_pkt(0);
        push_pkt(1);
        step(1'b1, '0);
        chk("t5_grant0", 32'(o_grant), 32'd1);
        guard = 0;
        while (owner >= 0 && pos < HDR + 3 && guard < 50) begin
            step(1'b1, (pos == 1) ? 2'b10 : 2'b00);
            guard++;
        end
        push_pkt(1);
        drive_and_check(1'b1, 2'b01);
        chk("t5_nopop", 32'(o_pop), 32'd0);
        finish_cycle();
        drive_and_check(1'b1, '0);
        chk("t5_valid_low", 32'(o_valid), 32'd0);
        finish_cycle();
        drive_and_check(1'b1, '0);
        chk("t5_src1_grant", 32'(o_grant), 32'd2);
        finish_cycle();
        drain(100);

        // T6: flush coincident with final byte acceptance
        dut_len_log.delete();
        push_pkt(0);
        step(1'b1, '0);
        base  = dut_pops;
        guard = 0;
        while (owner >= 0 && pos < FRAME - 1 && guard < 50) begin
            step(1'b1, '0);
            guard++;
        end
        drive_and_check(1'b1, 2'b01);
        chk("t6_nopop", 32'(o_pop), 32'd0);
        finish_cycle();
        drive_and_check(1'b1, '0);
        chk("t6_idle", 32'(o_busy), 32'd0);
        finish_cycle();
        chk("t6_pop_count", 32'(dut_pops - base), 32'(PKT_LEN - 1));
        chk("t6_trunc_pkts", 32'(dut_len_log.size()), 32'd1);
        if (dut_len_log.size() > 0)
            chk("t6_trunc_len", 32'(dut_len_log[dut_len_log.size() - 1]), 32'(FRAME - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
